// File: rtl/flit_pkg.sv
// Shared constants for the flit pipeline: flit width, flits per packet, packet
// width and the packetizer state encoding. The pipeline stage and downstream
// blocks import the same constants so widths always agree.
package flit_pkg;

    localparam int FLIT_W        = 4;
    localparam int FLITS_PER_PKT = 4;
    localparam int PKT_W         = FLIT_W * FLITS_PER_PKT;

    // IDLE: no packet held. SEND: presenting flit idx of the held packet.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/flit_packetizer.sv
// flit_packetizer
//   Accepts one packet per handshake and serialises it into FLITS_PER_PKT
//   consecutive flits (LSB flit first), one per clock, with head/tail/valid
//   sideband. The downstream pipeline never back-pressures, so once a packet
//   is held its flits are emitted unconditionally.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst         in   asynchronous active-high reset
//   pkt_in      in   packet payload, flit 0 = pkt_in[FLIT_W-1:0]
//   pkt_valid   in   pkt_in is valid
//   pkt_ready   out  block can accept pkt_in this cycle (combinational)
//   flit_out    out  current flit (registered)
//   flit_valid  out  flit_out carries packet data
//   flit_head   out  flit_out is flit 0 of a packet
//   flit_tail   out  flit_out is the last flit of a packet
//
// Handshake: a packet is transferred on a rising edge where pkt_valid and
// pkt_ready are both 1. While pkt_ready is 0, pkt_in and pkt_valid are ignored;
// the sender keeps pkt_valid/pkt_in stable until the transfer happens.
// pkt_ready is also high while the tail flit is out, so packets can run
// back-to-back with the next head directly after the tail.
module flit_packetizer #(
    parameter int FLIT_W        = flit_pkg::FLIT_W,
    parameter int FLITS_PER_PKT = flit_pkg::FLITS_PER_PKT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLIT_W*FLITS_PER_PKT-1:0] pkt_in,
    input  logic                            pkt_valid,
    output logic                            pkt_ready,
    output logic [FLIT_W-1:0]               flit_out,
    output logic                            flit_valid,
    output logic                            flit_head,
    output logic                            flit_tail
);

    import flit_pkg::*;

    localparam int PKT_W = FLIT_W * FLITS_PER_PKT;
    localparam int IDX_W = (FLITS_PER_PKT > 1) ? $clog2(FLITS_PER_PKT) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FLITS_PER_PKT - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [PKT_W-1:0]   hold, hold_n;
    logic [FLIT_W-1:0]  flit_out_n;
    logic               flit_valid_n, flit_head_n, flit_tail_n;
    logic               accept;

    // Ready when nothing is held, or when the tail is on the output this cycle.
    assign pkt_ready = !rst && ((state == IDLE) || (idx == LAST));
    assign accept    = pkt_valid && pkt_ready;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        hold_n       = hold;
        flit_out_n   = '0;
        flit_valid_n = 1'b0;
        flit_head_n  = 1'b0;
        flit_tail_n  = 1'b0;
        if (accept) begin
            // Flit 0 goes straight to the output; the remainder is shifted in hold.
            state_n      = SEND;
            idx_n        = '0;
            hold_n       = pkt_in >> FLIT_W;
            flit_out_n   = pkt_in[FLIT_W-1:0];
            flit_valid_n = 1'b1;
            flit_head_n  = 1'b1;
            flit_tail_n  = (LAST == '0);
        end else if (state == SEND && idx != LAST) begin
            idx_n        = idx + 1'b1;
            hold_n       = hold >> FLIT_W;
            flit_out_n   = hold[FLIT_W-1:0];
            flit_valid_n = 1'b1;
            flit_tail_n  = ((idx + 1'b1) == LAST);
        end else if (state == SEND) begin
            // Tail already presented and no follow-on packet: return to idle.
            state_n = IDLE;
            idx_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            hold       <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            flit_head  <= 1'b0;
            flit_tail  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            hold       <= hold_n;
            flit_out   <= flit_out_n;
            flit_valid <= flit_valid_n;
            flit_head  <= flit_head_n;
            flit_tail  <= flit_tail_n;
        end
    end

endmodule

// File: tb/tb_flit_packetizer.sv
// Bench for flit_packetizer: a 4x4 instance checked against a queue-of-flits
// reference model, plus a single-flit-per-packet instance.
module tb_flit_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default instance: 4-bit flits, 4 flits per packet.
    logic [15:0] pkt_in = '0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [3:0]  flit_out;
    logic        flit_valid, flit_head, flit_tail;

    // Single-flit instance.
    logic [3:0]  pkt_in1 = '0;
    logic        pkt_valid1 = 1'b0;
    logic        pkt_ready1;
    logic [3:0]  flit_out1;
    logic        flit_valid1, flit_head1, flit_tail1;

    int checks = 0;
    int errors = 0;

    // Flits still to be presented, each packed as {present, head, tail, data}.
    logic [6:0] exp_q[$];

    flit_packetizer #(.FLIT_W(4), .FLITS_PER_PKT(4)) dut (
        .clk(clk), .rst(rst), .pkt_in(pkt_in), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .flit_out(flit_out), .flit_valid(flit_valid),
        .flit_head(flit_head), .flit_tail(flit_tail)
    );

    flit_packetizer #(.FLIT_W(4), .FLITS_PER_PKT(1)) dut1 (
        .clk(clk), .rst(rst), .pkt_in(pkt_in1), .pkt_valid(pkt_valid1),
        .pkt_ready(pkt_ready1), .flit_out(flit_out1), .flit_valid(flit_valid1),
        .flit_head(flit_head1), .flit_tail(flit_tail1)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flit"}, {28'd0, flit_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, flit_valid}, 32'd0);
        check({tag, "_head"}, {31'd0, flit_head}, 32'd0);
        check({tag, "_tail"}, {31'd0, flit_tail}, 32'd0);
        check({tag, "_flit1"}, {28'd0, flit_out1}, 32'd0);
        check({tag, "_valid1"}, {31'd0, flit_valid1}, 32'd0);
    endtask

    // ---------------- driver: one clock of stimulus plus model update ----------------
    task automatic step(input logic v, input logic [15:0] d);
        logic       m_ready, acc, acc1;
        logic [6:0] cur;
        pkt_valid  = v;
        pkt_in     = d;
        pkt_valid1 = v;
        pkt_in1    = d[3:0];
        #1;
        // The block can take a new packet exactly when no flit remains to be shown
        // after the one currently on the output.
        m_ready = (exp_q.size() == 0);
        check("ready", {31'd0, pkt_ready}, {31'd0, m_ready});
        check("ready1", {31'd0, pkt_ready1}, 32'd1);
        acc  = v && m_ready;
        acc1 = v;
        @(posedge clk);
        #1;
        if (acc)
            for (int i = 0; i < 4; i++)
                exp_q.push_back({1'b1, (i == 0), (i == 3), d[4*i +: 4]});
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 7'd0;
        check("flit", {28'd0, flit_out}, {28'd0, cur[3:0]});
        check("valid", {31'd0, flit_valid}, {31'd0, cur[6]});
        check("head", {31'd0, flit_head}, {31'd0, cur[5]});
        check("tail", {31'd0, flit_tail}, {31'd0, cur[4]});
        check("flit1", {28'd0, flit_out1}, acc1 ? {28'd0, d[3:0]} : 32'd0);
        check("valid1", {31'd0, flit_valid1}, {31'd0, acc1});
        check("head1", {31'd0, flit_head1}, {31'd0, acc1});
        check("tail1", {31'd0, flit_tail1}, {31'd0, acc1});
    endtask

    // Assert reset between edges, hold it over an edge, release mid-cycle.
    task automatic reset_check(input string tag);
        rst = 1'b1;
        #1;
        check_outputs_zero({tag, "_async"});
        check({tag, "_ready_in_rst"}, {31'd0, pkt_ready}, 32'd0);
        check({tag, "_ready1_in_rst"}, {31'd0, pkt_ready1}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check_outputs_zero({tag, "_held"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_ready_rel"}, {31'd0, pkt_ready}, 32'd1);
        check({tag, "_ready1_rel"}, {31'd0, pkt_ready1}, 32'd1);
        check_outputs_zero({tag, "_rel"});
    endtask

    // ---------------- sequence ----------------
    initial begin
        #3;
        reset_check("rst0");

        // Single packet, one-cycle valid: 3,C,5,A then idle zeros.
        step(1'b1, 16'hA5C3);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000);

        // Back-to-back: valid held until each packet is taken.
        step(1'b1, 16'h1234);
        while (exp_q.size() != 0) step(1'b1, 16'h1234);
        step(1'b1, 16'h5678);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000);

        // Stall: valid held with pkt_in changing while not ready.
        step(1'b1, 16'h1111);
        for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom));
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000);

        // Reset mid-packet after flit 1 of BEEF.
        step(1'b1, 16'hBEEF);
        step(1'b0, 16'h0000);
        reset_check("rst_mid");
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000);
        step(1'b1, 16'h4C2D);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom));
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=%0d expected=0", checks);
        $fatal(1, "timeout");
    end

endmodule
